// File: rtl/ring_writer_pkg.sv
// Shared types, constants and slot-index arithmetic for the ring buffer writer.
package ring_writer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA_WR = 2'd1,
    TAIL_WR = 2'd2
  } state_t;

  localparam int LINE_BYTES = 64;
  localparam int LINE_SHIFT = 6;

  localparam logic [63:0] STRB_FULL = {64{1'b1}};
  localparam logic [63:0] STRB_PTR  = 64'h0000_0000_0000_000F;

  // Evaluated at 64 bits so callers of any index width can zero-extend into it.
  function automatic logic [63:0] ptr_next(input logic [63:0] tail,
                                           input logic [63:0] capacity);
    logic [63:0] inc;
    inc = tail + 64'd1;
    return (inc == capacity) ? 64'd0 : inc;
  endfunction

endpackage

// File: rtl/ring_writer.sv
// Packet-to-ring writer: each packet is one data write followed by a tail write-back,
// with the tail pointer committed only once the tail write is acknowledged.
module ring_writer
  import ring_writer_pkg::*;
#(
  parameter int PTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  input  logic [63:0]          cfg_base_addr,
  input  logic [PTR_WIDTH-1:0] cfg_capacity,
  input  logic [63:0]          cfg_tail_addr,
  input  logic [PTR_WIDTH-1:0] head_ptr,
  input  logic                 in_valid,
  input  logic [511:0]         in_data,
  output logic                 in_ready,
  output logic                 wvalid,
  output logic [63:0]          waddr,
  output logic [63:0]          wstrb,
  output logic [511:0]         wdata,
  input  logic                 wready,
  output logic [PTR_WIDTH-1:0] tail_ptr,
  output logic [31:0]          pkt_count
);

  state_t               state;
  state_t               state_nxt;
  logic [511:0]         data_r;
  logic [63:0]          waddr_r;
  logic [PTR_WIDTH-1:0] tail_nxt_r;
  logic [PTR_WIDTH-1:0] tail_nxt;
  logic                 full;
  logic                 accept;

  assign tail_nxt = PTR_WIDTH'(ptr_next(64'(tail_ptr), 64'(cfg_capacity)));
  assign full     = (tail_nxt == head_ptr) || (cfg_capacity < PTR_WIDTH'(2));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wvalid    = 1'b0;
    waddr     = 64'd0;
    wstrb     = 64'd0;
    wdata     = 512'd0;
    case (state)
      IDLE: begin
        in_ready = cfg_enable && !full && !rst;
        if (in_valid && in_ready) state_nxt = DATA_WR;
      end
      DATA_WR: begin
        wvalid = 1'b1;
        waddr  = waddr_r;
        wstrb  = STRB_FULL;
        wdata  = data_r;
        if (wready) state_nxt = TAIL_WR;
      end
      TAIL_WR: begin
        wvalid = 1'b1;
        waddr  = cfg_tail_addr;
        wstrb  = STRB_PTR;
        wdata  = 512'(tail_nxt_r);
        if (wready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tail_ptr   <= '0;
      pkt_count  <= 32'd0;
      data_r     <= 512'd0;
      waddr_r    <= 64'd0;
      tail_nxt_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_r     <= in_data;
        waddr_r    <= cfg_base_addr + (64'(tail_ptr) << LINE_SHIFT);
        tail_nxt_r <= tail_nxt;
      end
      // The host only ever observes the new tail after its write-back has landed.
      if (state == TAIL_WR && wready) begin
        tail_ptr  <= tail_nxt_r;
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ring_writer.sv
// Directed bench for ring_writer with a write-request scoreboard and a reference ring model.
module tb_ring_writer;

  localparam int PW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_enable = 1'b0;
  logic [63:0]    cfg_base_addr = 64'd0;
  logic [PW-1:0]  cfg_capacity = '0;
  logic [63:0]    cfg_tail_addr = 64'd0;
  logic [PW-1:0]  head_ptr = '0;
  logic           in_valid = 1'b0;
  logic [511:0]   in_data = 512'd0;
  logic           in_ready;
  logic           wvalid;
  logic [63:0]    waddr;
  logic [63:0]    wstrb;
  logic [511:0]   wdata;
  logic           wready = 1'b0;
  logic [PW-1:0]  tail_ptr;
  logic [31:0]    pkt_count;

  ring_writer #(.PTR_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_base_addr(cfg_base_addr),
    .cfg_capacity(cfg_capacity), .cfg_tail_addr(cfg_tail_addr), .head_ptr(head_ptr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wvalid(wvalid),
    .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .wready(wready),
    .tail_ptr(tail_ptr), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  addr;
    logic [63:0]  strb;
    logic [511:0] data;
  } wr_t;

  wr_t sb[$];

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] m_tail;
  logic [PW-1:0] m_pend;
  logic [31:0]   m_count;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] model_next();
    return (m_tail + 1'b1 == cfg_capacity) ? '0 : m_tail + 1'b1;
  endfunction

  function automatic logic model_ready();
    return cfg_enable && !((model_next() == head_ptr) || (cfg_capacity < 2));
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_wvalid", 512'(wvalid), 512'd0);
    chk("rst_in_ready", 512'(in_ready), 512'd0);
    chk("rst_tail_ptr", 512'(tail_ptr), 512'd0);
    chk("rst_pkt_count", 512'(pkt_count), 512'd0);
    rst = 1'b0;
    sb.delete();
    m_tail = '0;
    m_count = 32'd0;
  endtask

  // Offer one packet; the model decides whether it should be taken.
  task automatic send_pkt(input logic [511:0] d, input int wait_cyc);
    logic acc;
    logic exp_acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    #1;
    exp_acc = model_ready();
    for (int i = 0; i < wait_cyc && !acc; i++) begin
      if (in_ready) acc = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("accept", 512'(acc), 512'(exp_acc));
    if (acc) begin
      m_pend = model_next();
      sb.push_back('{cfg_base_addr + (64'(m_tail) << 6), {64{1'b1}}, d});
      sb.push_back('{cfg_tail_addr, 64'h0F, 512'(m_pend)});
      chk("latency_wvalid", 512'(wvalid), 512'd1);
    end
  endtask

  // Wait for a request, compare it, hold it for 'delay' cycles, then pulse wready.
  task automatic serve(input int delay, input logic is_tail, input logic ack);
    wr_t e;
    for (int i = 0; i < 50 && !wvalid; i++) tick();
    if (!wvalid) begin
      chk("wvalid_timeout", 512'(wvalid), 512'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 512'(sb.size()), 512'd1);
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k <= delay; k++) begin
      chk("waddr", 512'(waddr), 512'(e.addr));
      chk("wstrb", 512'(wstrb), 512'(e.strb));
      chk("wdata", wdata, e.data);
      chk("wvalid_hold", 512'(wvalid), 512'd1);
      chk("no_accept_busy", 512'(in_ready), 512'd0);
      chk("tail_uncommitted", 512'(tail_ptr), 512'(m_tail));
      if (k < delay) tick();
    end
    if (!ack) return;
    wready = 1'b1;
    tick();
    wready = 1'b0;
    if (is_tail) begin
      m_tail = m_pend;
      m_count++;
      chk("wvalid_drop", 512'(wvalid), 512'd0);
      chk("tail_ptr", 512'(tail_ptr), 512'(m_tail));
      chk("pkt_count", 512'(pkt_count), 512'(m_count));
    end
  endtask

  initial begin
    cfg_base_addr = 64'h1000;
    cfg_tail_addr = 64'h8000;
    cfg_capacity = PW'(4);
    head_ptr = '0;
    tick();
    do_reset();

    // Basic write
    cfg_enable = 1'b1;
    send_pkt({16{32'hD0D0_0001}}, 5);
    serve(0, 1'b0, 1'b1);
    serve(0, 1'b1, 1'b1);
    chk("basic_tail", 512'(tail_ptr), 512'd1);

    // Full stall then release via head advance
    do_reset();
    for (int p = 0; p < 3; p++) begin
      send_pkt({16{32'hA000_0000 + 32'(p)}}, 5);
      serve(0, 1'b0, 1'b1);
      serve(0, 1'b1, 1'b1);
    end
    in_valid = 1'b1;
    in_data = {16{32'hA000_0003}};
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("full_in_ready", 512'(in_ready), 512'(model_ready()));
      chk("full_no_write", 512'(wvalid), 512'd0);
    end
    head_ptr = PW'(1);
    send_pkt({16{32'hA000_0003}}, 5);
    serve(0, 1'b0, 1'b1);
    serve(0, 1'b1, 1'b1);
    chk("wrap_tail", 512'(tail_ptr), 512'd0);

    // Enable drop during the data write; head moved mid-flight must not matter
    head_ptr = '0;
    send_pkt({8{64'hE0E0_1234_5678_9ABC}}, 5);
    cfg_enable = 1'b0;
    head_ptr = PW'(1);
    serve(2, 1'b0, 1'b1);
    serve(2, 1'b1, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drop_in_ready", 512'(in_ready), 512'(model_ready()));
    end
    in_valid = 1'b0;
    chk("drop_tail", 512'(tail_ptr), 512'd1);

    // Slow responder
    cfg_enable = 1'b1;
    head_ptr = '0;
    send_pkt({4{128'h5151_0000_FFFF_1111_2222_3333_4444_5555}}, 5);
    in_valid = 1'b1;
    serve(20, 1'b0, 1'b1);
    serve(20, 1'b1, 1'b1);
    in_valid = 1'b0;

    // Reset while the tail write is outstanding
    send_pkt({16{32'hBEEF_0000}}, 5);
    serve(0, 1'b0, 1'b1);
    serve(3, 1'b1, 1'b0);
    chk("pre_rst_count", 512'(pkt_count), 512'(m_count));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_wvalid", 512'(wvalid), 512'd0);
    chk("mid_rst_tail", 512'(tail_ptr), 512'd0);
    chk("mid_rst_count", 512'(pkt_count), 512'd0);
    sb.delete();
    m_tail = '0;
    m_count = 32'd0;

    // Degenerate capacities
    for (int c = 0; c < 2; c++) begin
      cfg_capacity = PW'(c);
      head_ptr = PW'(3);
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick();
        chk("degen_in_ready", 512'(in_ready), 512'(model_ready()));
        chk("degen_wvalid", 512'(wvalid), 512'd0);
      end
      in_valid = 1'b0;
    end
    chk("degen_count", 512'(pkt_count), 512'd0);
    chk("sb_drained", 512'(sb.size()), 512'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
